// File: rtl/sccb_cfg_sequencer.sv
// Walks an OV5642 init table and issues one SCCB write per entry, with delay/end markers and NACK retry.
// Optional readback verify of every write is enabled by defining SCCB_CFG_VERIFY_EN.
module sccb_cfg_sequencer #(
  parameter int          ROM_AW        = 10,
  parameter logic [7:0]  DEVICE_ID     = 8'h78,
  parameter int          CLK_FREQ      = 100_000_000,
  parameter int          DELAY_UNIT_US = 1000,
  parameter int          MAX_RETRY     = 3,
  parameter int          GAP_CYCLES    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ROM_AW-1:0] o_err_addr,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [23:0]       i_rom_data,
  output logic              o_sccb_req,
  output logic              o_sccb_rd,
  output logic [7:0]        o_sccb_id,
  output logic [15:0]       o_sccb_sub_addr,
  output logic [7:0]        o_sccb_wr_data,
  input  logic              i_sccb_done,
  input  logic              i_sccb_nack,
  input  logic [7:0]        i_sccb_rd_data
);

  localparam logic [31:0]       PRESCALE  = 32'(CLK_FREQ / 1_000_000);
  localparam logic [31:0]       DLY_UNIT  = 32'(DELAY_UNIT_US);
  localparam int                RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [15:0]       GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [ROM_AW-1:0] ADDR_LAST = {ROM_AW{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_WRITE = 4'd3, S_READ = 4'd4,
    S_GAP  = 4'd5, S_DELAY = 4'd6, S_NEXT   = 4'd7, S_DONE  = 4'd8, S_ERR  = 4'd9
  } state_t;

  state_t state_r, state_s, gap_ret_r, gap_ret_s;
  logic [15:0]       gap_cnt_r, gap_cnt_s;
  logic [31:0]       pre_cnt_r, pre_cnt_s, dly_cnt_r, dly_cnt_s;
  logic [RW-1:0]     retry_r, retry_s;
  logic              busy_r, busy_s, done_r, done_s, err_r, err_s;
  logic [ROM_AW-1:0] err_addr_r, err_addr_s, rom_addr_r, rom_addr_s;
  logic              req_r, req_s, rd_r, rd_s;
  logic [7:0]        id_r, id_s, wdata_r, wdata_s;
  logic [15:0]       sub_r, sub_s;

`ifndef SCCB_CFG_VERIFY_EN
  logic unused_rd_data_s;
  assign unused_rd_data_s = ^i_sccb_rd_data;
`endif

  // Next-state and next-output computation for the table walk.
  always_comb begin
    state_s    = state_r;
    gap_ret_s  = gap_ret_r;
    gap_cnt_s  = gap_cnt_r;
    pre_cnt_s  = pre_cnt_r;
    dly_cnt_s  = dly_cnt_r;
    retry_s    = retry_r;
    busy_s     = busy_r;
    done_s     = done_r;
    err_s      = err_r;
    err_addr_s = err_addr_r;
    rom_addr_s = rom_addr_r;
    req_s      = req_r;
    rd_s       = rd_r;
    id_s       = id_r;
    sub_s      = sub_r;
    wdata_s    = wdata_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) begin
          state_s    = S_FETCH;
          busy_s     = 1'b1;
          done_s     = 1'b0;
          err_s      = 1'b0;
          err_addr_s = {ROM_AW{1'b0}};
          rom_addr_s = {ROM_AW{1'b0}};
          retry_s    = {RW{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      S_FETCH: state_s = S_DECODE;
      S_DECODE: begin
        sub_s   = i_rom_data[23:8];
        wdata_s = i_rom_data[7:0];
        if (i_rom_data[23:8] == 16'hFFFF) begin
          state_s = S_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else if (i_rom_data[23:8] == 16'hFFFE) begin
          pre_cnt_s = 32'd0;
          dly_cnt_s = {24'd0, i_rom_data[7:0]} * DLY_UNIT;
          state_s   = (i_rom_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
        end else begin
          state_s = S_WRITE;
          req_s   = 1'b1;
          rd_s    = 1'b0;
          id_s    = DEVICE_ID;
        end
      end
      S_WRITE: begin
        if (i_sccb_done && req_r) begin
          req_s     = 1'b0;
          gap_cnt_s = 16'd0;
          if (!i_sccb_nack) begin
`ifdef SCCB_CFG_VERIFY_EN
            state_s   = S_GAP;
            gap_ret_s = S_READ;
`else
            state_s   = S_NEXT;
`endif
          end else if (retry_r < RETRY_MAX) begin
            retry_s   = retry_r + 1'b1;
            state_s   = S_GAP;
            gap_ret_s = S_WRITE;
          end else begin
            state_s    = S_ERR;
            err_s      = 1'b1;
            busy_s     = 1'b0;
            err_addr_s = rom_addr_r;
          end
        end else begin
          state_s = S_WRITE;
        end
      end
`ifdef SCCB_CFG_VERIFY_EN
      // A NACK or a data mismatch on readback retries the whole write+read pair.
      S_READ: begin
        if (i_sccb_done && req_r) begin
          req_s     = 1'b0;
          gap_cnt_s = 16'd0;
          if (!i_sccb_nack && (i_sccb_rd_data == wdata_r)) begin
            state_s = S_NEXT;
          end else if (retry_r < RETRY_MAX) begin
            retry_s   = retry_r + 1'b1;
            state_s   = S_GAP;
            gap_ret_s = S_WRITE;
          end else begin
            state_s    = S_ERR;
            err_s      = 1'b1;
            busy_s     = 1'b0;
            err_addr_s = rom_addr_r;
          end
        end else begin
          state_s = S_READ;
        end
      end
`endif
      S_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = gap_ret_r;
          if (gap_ret_r == S_WRITE) begin
            req_s = 1'b1;
            rd_s  = 1'b0;
            id_s  = DEVICE_ID;
          end else if (gap_ret_r == S_READ) begin
            req_s = 1'b1;
            rd_s  = 1'b1;
            id_s  = DEVICE_ID | 8'h01;
          end else begin
            req_s = 1'b0;
          end
        end else begin
          gap_cnt_s = gap_cnt_r + 16'd1;
        end
      end
      S_DELAY: begin
        if (pre_cnt_r == PRESCALE - 32'd1) begin
          pre_cnt_s = 32'd0;
          dly_cnt_s = dly_cnt_r - 32'd1;
          state_s   = (dly_cnt_r == 32'd1) ? S_NEXT : S_DELAY;
        end else begin
          pre_cnt_s = pre_cnt_r + 32'd1;
        end
      end
      S_NEXT: begin
        retry_s = {RW{1'b0}};
        if (rom_addr_r == ADDR_LAST) begin
          state_s = S_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          rom_addr_s = rom_addr_r + 1'b1;
          gap_cnt_s  = 16'd0;
          gap_ret_s  = S_FETCH;
          state_s    = S_GAP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r    <= S_IDLE;
      gap_ret_r  <= S_FETCH;
      gap_cnt_r  <= 16'd0;
      pre_cnt_r  <= 32'd0;
      dly_cnt_r  <= 32'd0;
      retry_r    <= {RW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_addr_r <= {ROM_AW{1'b0}};
      rom_addr_r <= {ROM_AW{1'b0}};
      req_r      <= 1'b0;
      rd_r       <= 1'b0;
      id_r       <= 8'd0;
      sub_r      <= 16'd0;
      wdata_r    <= 8'd0;
    end else begin
      state_r    <= state_s;
      gap_ret_r  <= gap_ret_s;
      gap_cnt_r  <= gap_cnt_s;
      pre_cnt_r  <= pre_cnt_s;
      dly_cnt_r  <= dly_cnt_s;
      retry_r    <= retry_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      err_addr_r <= err_addr_s;
      rom_addr_r <= rom_addr_s;
      req_r      <= req_s;
      rd_r       <= rd_s;
      id_r       <= id_s;
      sub_r      <= sub_s;
      wdata_r    <= wdata_s;
    end
  end

  assign o_busy          = busy_r;
  assign o_done          = done_r;
  assign o_err           = err_r;
  assign o_err_addr      = err_addr_r;
  assign o_rom_addr      = rom_addr_r;
  assign o_sccb_req      = req_r;
  assign o_sccb_rd       = rd_r;
  assign o_sccb_id       = id_r;
  assign o_sccb_sub_addr = sub_r;
  assign o_sccb_wr_data  = wdata_r;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer: synchronous ROM model and a scripted SCCB master.
module tb_sccb_cfg_sequencer;

`ifdef SCCB_CFG_VERIFY_EN
  localparam int TB_RETRY = 1;
`else
  localparam int TB_RETRY = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [3:0]  err_addr, rom_addr;
  logic [23:0] rom_q = 24'd0;
  logic        req, rd;
  logic [7:0]  id, wr_data;
  logic [15:0] sub_addr;
  logic        sccb_done = 1'b0;
  logic        sccb_nack = 1'b0;
  logic [7:0]  sccb_rd_data = 8'd0;
  logic [23:0] rom [16];

  int vecs = 0;
  int misses = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  sccb_cfg_sequencer #(
    .ROM_AW(4), .DEVICE_ID(8'h78), .CLK_FREQ(100_000_000),
    .DELAY_UNIT_US(1), .MAX_RETRY(TB_RETRY), .GAP_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(busy), .o_done(done), .o_err(err), .o_err_addr(err_addr),
    .o_rom_addr(rom_addr), .i_rom_data(rom_q),
    .o_sccb_req(req), .o_sccb_rd(rd), .o_sccb_id(id),
    .o_sccb_sub_addr(sub_addr), .o_sccb_wr_data(wr_data),
    .i_sccb_done(sccb_done), .i_sccb_nack(sccb_nack), .i_sccb_rd_data(sccb_rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 24'd0;
  endtask

  // Wait for one request, check its fields and stability, then answer it.
  task automatic serve(input bit nack, input logic [7:0] rdd, input logic [15:0] exp_sub,
                       input logic [7:0] exp_dat, input bit exp_rd, output int wait_n);
    logic [7:0] exp_id;
    exp_id = exp_rd ? 8'h79 : 8'h78;
    wait_n = 0;
    while (req !== 1'b1 && wait_n < 2000) begin
      tick();
      wait_n++;
    end
    vecs++;
    if (req !== 1'b1) begin
      misses++;
      $display("FAIL req_timeout: req=%b after %0d cycles, required 1", req, wait_n);
      return;
    end
    vecs++;
    if ({rd, id, sub_addr, wr_data} !== {exp_rd, exp_id, exp_sub, exp_dat}) begin
      misses++;
      $display("FAIL req_fields: rd=%b id=%h sub=%h data=%h, required rd=%b id=%h sub=%h data=%h",
               rd, id, sub_addr, wr_data, exp_rd, exp_id, exp_sub, exp_dat);
    end
    repeat (3) tick();
    vecs++;
    if ({req, rd, id, sub_addr, wr_data} !== {1'b1, exp_rd, exp_id, exp_sub, exp_dat}) begin
      misses++;
      $display("FAIL req_hold: req=%b sub=%h data=%h, required req=1 sub=%h data=%h",
               req, sub_addr, wr_data, exp_sub, exp_dat);
    end
    sccb_done = 1'b1;
    sccb_nack = nack;
    sccb_rd_data = rdd;
    tick();
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    vecs++;
    if (req !== 1'b0) begin
      misses++;
      $display("FAIL req_drop: req=%b one cycle after done, required 0", req);
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 4000) begin
      tick();
      n++;
    end
    vecs++;
    if (done !== 1'b1 && err !== 1'b1) begin
      misses++;
      $display("FAIL end_timeout: done=%b err=%b after %0d cycles, required one of them 1", done, err, n);
    end
  endtask

  task automatic check_done_ok(input string tag);
    vecs++;
    if ({done, err, busy} !== 3'b100) begin
      misses++;
      $display("FAIL %s: done=%b err=%b busy=%b, required done=1 err=0 busy=0", tag, done, err, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    vecs++;
    if ({busy, done, err, err_addr, rom_addr, req, rd, id, sub_addr, wr_data} !== 48'd0) begin
      misses++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b req=%b addr=%h id=%h, required all 0",
               busy, done, err, req, rom_addr, id);
    end
    rst_n = 1'b1;
    tick();
  endtask

`ifndef SCCB_CFG_VERIFY_EN
  task automatic load_walk_table();
    clear_rom();
    rom[0] = 24'h3008_82;
    rom[1] = 24'hFFFE_02;
    rom[2] = 24'h3103_93;
    rom[3] = 24'hFFFF_00;
  endtask

  task automatic test_walk_delay();
    int w;
    load_walk_table();
    pulse_start();
    vecs++;
    if ({busy, rom_addr} !== {1'b1, 4'd0}) begin
      misses++;
      $display("FAIL start_accept: busy=%b addr=%0d, required busy=1 addr=0", busy, rom_addr);
    end
    serve(1'b0, 8'h00, 16'h3008, 8'h82, 1'b0, w);
    serve(1'b0, 8'h00, 16'h3103, 8'h93, 1'b0, w);
    vecs++;
    if (w < 200 || w > 260) begin
      misses++;
      $display("FAIL delay_gap: %0d cycles between writes, required 200..260", w);
    end
    wait_end();
    check_done_ok("walk_end");
  endtask

  task automatic test_zero_delay();
    int w;
    clear_rom();
    rom[0] = 24'h3008_01;
    rom[1] = 24'hFFFE_00;
    rom[2] = 24'h3009_02;
    rom[3] = 24'hFFFF_00;
    pulse_start();
    serve(1'b0, 8'h00, 16'h3008, 8'h01, 1'b0, w);
    serve(1'b0, 8'h00, 16'h3009, 8'h02, 1'b0, w);
    vecs++;
    if (w > 60) begin
      misses++;
      $display("FAIL zero_delay: %0d cycles between writes, required at most 60", w);
    end
    wait_end();
    check_done_ok("zero_delay_end");
  endtask

  task automatic test_nack_retry();
    int w;
    clear_rom();
    rom[0] = 24'h3017_FF;
    rom[1] = 24'hFFFF_00;
    pulse_start();
    serve(1'b1, 8'h00, 16'h3017, 8'hFF, 1'b0, w);
    serve(1'b1, 8'h00, 16'h3017, 8'hFF, 1'b0, w);
    vecs++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      misses++;
      $display("FAIL retry_midway: err=%b busy=%b, required err=0 busy=1", err, busy);
    end
    serve(1'b0, 8'h00, 16'h3017, 8'hFF, 1'b0, w);
    wait_end();
    check_done_ok("retry_end");
  endtask

  task automatic test_retry_exhaust();
    int w;
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {16'h3000 + 16'(i), 8'(i)};
    rom[5] = 24'h3005_AA;
    rom[6] = 24'hFFFF_00;
    pulse_start();
    for (int i = 0; i < 5; i++) serve(1'b0, 8'h00, 16'h3000 + 16'(i), 8'(i), 1'b0, w);
    for (int i = 0; i < 4; i++) serve(1'b1, 8'h00, 16'h3005, 8'hAA, 1'b0, w);
    wait_end();
    vecs++;
    if ({err, done, busy, err_addr} !== {3'b100, 4'd5}) begin
      misses++;
      $display("FAIL exhaust: err=%b done=%b busy=%b err_addr=%0d, required err=1 done=0 busy=0 err_addr=5",
               err, done, busy, err_addr);
    end
    repeat (20) tick();
    vecs++;
    if (req !== 1'b0) begin
      misses++;
      $display("FAIL exhaust_no_fifth: req=%b after error, required 0", req);
    end
    pulse_start();
    vecs++;
    if ({err, err_addr, busy, rom_addr} !== {1'b0, 4'd0, 1'b1, 4'd0}) begin
      misses++;
      $display("FAIL restart_clear: err=%b err_addr=%0d busy=%b addr=%0d, required 0 0 1 0",
               err, err_addr, busy, rom_addr);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int n, w;
    clear_rom();
    rom[0] = 24'h3008_82;
    rom[1] = 24'hFFFF_00;
    pulse_start();
    n = 0;
    while (req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    tick();
    vecs++;
    if ({busy, done, err, err_addr, rom_addr, req, rd, id, sub_addr, wr_data} !== 48'd0) begin
      misses++;
      $display("FAIL reset_mid: req=%b busy=%b id=%h sub=%h, required all 0", req, busy, id, sub_addr);
    end
    rst_n = 1'b1;
    tick();
    pulse_start();
    vecs++;
    if ({busy, rom_addr} !== {1'b1, 4'd0}) begin
      misses++;
      $display("FAIL reset_restart: busy=%b addr=%0d, required busy=1 addr=0", busy, rom_addr);
    end
    serve(1'b0, 8'h00, 16'h3008, 8'h82, 1'b0, w);
    wait_end();
    check_done_ok("reset_restart_end");
  endtask

  task automatic test_start_while_busy();
    int w;
    load_walk_table();
    pulse_start();
    serve(1'b0, 8'h00, 16'h3008, 8'h82, 1'b0, w);
    start = 1'b1;
    sccb_done = 1'b1;
    sccb_nack = 1'b1;
    tick();
    start = 1'b0;
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    serve(1'b0, 8'h00, 16'h3103, 8'h93, 1'b0, w);
    vecs++;
    if (rom_addr !== 4'd2) begin
      misses++;
      $display("FAIL busy_start_addr: addr=%0d at second write, required 2", rom_addr);
    end
    wait_end();
    check_done_ok("busy_start_end");
  endtask

  task automatic test_implicit_end();
    int w;
    for (int i = 0; i < 16; i++) rom[i] = {16'h3100 + 16'(i), 8'(8'hA0 + i)};
    pulse_start();
    for (int i = 0; i < 16; i++) serve(1'b0, 8'h00, 16'h3100 + 16'(i), 8'(8'hA0 + i), 1'b0, w);
    wait_end();
    check_done_ok("implicit_end");
    vecs++;
    if (rom_addr !== 4'd15) begin
      misses++;
      $display("FAIL implicit_end_addr: addr=%0d, required 15 (no wrap)", rom_addr);
    end
  endtask
`else
  task automatic test_verify();
    int w;
    clear_rom();
    rom[0] = 24'h3008_55;
    rom[1] = 24'hFFFF_00;
    pulse_start();
    serve(1'b0, 8'h00, 16'h3008, 8'h55, 1'b0, w);
    serve(1'b0, 8'h00, 16'h3008, 8'h55, 1'b1, w);
    serve(1'b0, 8'h00, 16'h3008, 8'h55, 1'b0, w);
    serve(1'b0, 8'h00, 16'h3008, 8'h55, 1'b1, w);
    wait_end();
    vecs++;
    if ({err, done, busy, err_addr} !== {3'b100, 4'd0}) begin
      misses++;
      $display("FAIL verify_err: err=%b done=%b busy=%b err_addr=%0d, required 1 0 0 0",
               err, done, busy, err_addr);
    end
    pulse_start();
    serve(1'b0, 8'h00, 16'h3008, 8'h55, 1'b0, w);
    serve(1'b0, 8'h55, 16'h3008, 8'h55, 1'b1, w);
    wait_end();
    check_done_ok("verify_ok_end");
  endtask
`endif

  initial begin
    clear_rom();
    test_reset();
`ifndef SCCB_CFG_VERIFY_EN
    test_walk_delay();
    test_zero_delay();
    test_nack_retry();
    test_retry_exhaust();
    test_reset_mid();
    test_start_while_busy();
    test_implicit_end();
`else
    test_verify();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
